// File: rtl/mmio_console_pkg.sv
// rtl/mmio_console_pkg.sv - shared constants and types for the MMIO console
package mmio_console_pkg;

    localparam logic [31:0] FINI_CODE = 32'h0002_0000;

    localparam int ST_FULL = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_FINI = 2;
    localparam int ST_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/mmio_console_uart_tx.sv
// rtl/mmio_console_uart_tx.sv - 8N1 serializer with back-to-back frame support
module uart_tx
    import mmio_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t         state;
    logic [BW-1:0]     baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              bit_last;

    assign bit_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    // Ready in the final stop cycle lets the next start bit follow with no gap.
    assign ready_o  = (state == IDLE) || ((state == STOP) && bit_last);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd_o    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        shreg    <= data_i;
                        baud_cnt <= '0;
                        txd_o    <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd_o    <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd_o <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_o   <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        baud_cnt <= '0;
                        if (valid_i) begin
                            shreg <= data_i;
                            txd_o <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mmio_console.sv
// rtl/mmio_console.sv - bus-mapped console: character FIFO, UART output, finish flag
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dbus_addr_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_wdata_i,
    input  logic        dbus_rvalid_i,
    output logic        dbus_stall_o,
    output logic [31:0] dbus_rdata_o,
    output logic        txd_o,
    output logic        busy_o,
    output logic        fini_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic          sel;
    logic          is_fini;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          tx_ready;
    logic          frame_active;
    logic [ST_W-1:0] status;
    logic          addr_unused;

    assign addr_unused = ^dbus_addr_i[30:0];

    assign sel     = dbus_addr_i[31];
    assign is_fini = (dbus_wdata_i == FINI_CODE);
    assign full    = (count == (AW + 1)'(FIFO_DEPTH));
    assign empty   = (count == '0);

    // Full is judged on the current count, so a same-cycle pop never frees a slot.
    assign dbus_stall_o = sel && dbus_wvalid_i && full && !is_fini;
    assign push         = sel && dbus_wvalid_i && !is_fini && !full;
    assign pop          = tx_ready && !empty;

    assign busy_o = !empty || frame_active;

    always_comb begin
        status          = '0;
        status[ST_FULL] = full;
        status[ST_BUSY] = busy_o;
        status[ST_FINI] = fini_o;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= dbus_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            fini_o       <= 1'b0;
            dbus_rdata_o <= '0;
            frame_active <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sel && dbus_wvalid_i && is_fini) begin
                fini_o <= 1'b1;
            end
            if (sel && dbus_rvalid_i) begin
                dbus_rdata_o <= {{(32 - ST_W){1'b0}}, status};
            end
            // Mirrors "transmitter not idle" without exposing its state.
            if (pop) begin
                frame_active <= 1'b1;
            end else if (tx_ready) begin
                frame_active <= 1'b0;
            end
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(!empty),
        .data_i (mem[rptr]),
        .ready_o(tx_ready),
        .txd_o  (txd_o)
    );

endmodule

// File: tb/tb_mmio_console.sv
// tb/tb_mmio_console.sv - self-checking bench for mmio_console
module tb_mmio_console;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] FINI = 32'h0002_0000;
    localparam logic [31:0] DEV  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic        rvalid = 1'b0;
    logic        stall;
    logic [31:0] rdata;
    logic        txd;
    logic        busy;
    logic        fini;

    always #5 clk = ~clk;

    mmio_console #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .dbus_addr_i  (addr),
        .dbus_wvalid_i(wvalid),
        .dbus_wdata_i (wdata),
        .dbus_rvalid_i(rvalid),
        .dbus_stall_o (stall),
        .dbus_rdata_o (rdata),
        .txd_o        (txd),
        .busy_o       (busy),
        .fini_o       (fini)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of pending characters plus a frame-position timer.
    byte unsigned mq[$];
    byte unsigned started[$];
    logic         m_active = 1'b0;
    int           m_pos = 0;
    logic [9:0]   m_line = '1;
    logic         m_fini = 1'b0;
    logic [31:0]  m_rdata = '0;
    bit           chk_en = 1'b0;

    function automatic logic m_busy();
        return (mq.size() != 0) || m_active;
    endfunction

    always @(posedge clk) begin : model
        logic         m_sel, m_fc, m_full, m_push, m_pop;
        byte unsigned b;
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_fini   = 1'b0;
            m_rdata  = '0;
        end else begin
            m_sel  = addr[31];
            m_fc   = (wdata == FINI);
            m_full = (mq.size() == DEPTH);
            m_push = m_sel && wvalid && !m_fc && !m_full;
            m_pop  = (mq.size() != 0) && (!m_active || m_pos == FRAME - 1);
            if (m_sel && rvalid)
                m_rdata = {29'b0, m_fini, m_busy(), m_full};
            if (m_sel && wvalid && m_fc)
                m_fini = 1'b1;
            if (m_pop) begin
                b = mq.pop_front();
                started.push_back(b);
                m_line   = {1'b1, b, 1'b0};
                m_pos    = 0;
                m_active = 1'b1;
            end else if (m_active) begin
                if (m_pos == FRAME - 1) m_active = 1'b0;
                else m_pos++;
            end
            if (m_push)
                mq.push_back(wdata[7:0]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("txd", txd, m_active ? m_line[m_pos / CPB] : 1'b1);
            chk("busy", busy, m_busy());
            chk("fini", fini, m_fini);
            chk("rdata", rdata, m_rdata);
            chk("stall", stall, addr[31] && wvalid && (mq.size() == DEPTH) && (wdata != FINI));
        end
    end

    int busy_cycles = 0;
    always @(negedge clk) if (busy) busy_cycles++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        int n;
        addr   = a;
        wdata  = d;
        wvalid = 1'b1;
        #1;
        n = 0;
        while (stall && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 5000) chk("store_wait", stall, 1'b0);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        addr   = '0;
        wdata  = '0;
    endtask

    task automatic load();
        addr   = DEV;
        rvalid = 1'b1;
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        addr   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] line;
        int         n;
        int         lows;
        int         highs;

        tick(2);
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fini", fini, 1'b0);
        chk("rst_rdata", rdata, 32'h0);

        // Test 1: single 'A' frame.
        store(DEV, 32'h41);
        @(negedge clk);
        chk("t1_before_pop_txd", txd, 1'b1);
        line = 10'b1_0100_0001_0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("t1_line", txd, line[i / CPB]);
            if (i == FRAME - 1) chk("t1_busy_in_stop", busy, 1'b1);
        end
        @(negedge clk);
        chk("t1_busy_drop", busy, 1'b0);
        chk("t1_idle_txd", txd, 1'b1);

        // Test 4: unselected store.
        addr   = 32'h0000_1000;
        wdata  = 32'h55;
        wvalid = 1'b1;
        #1;
        chk("t4_no_stall", stall, 1'b0);
        tick(1);
        wvalid = 1'b0;
        addr   = '0;
        tick(3);
        @(negedge clk);
        chk("t4_busy", busy, 1'b0);
        chk("t4_txd", txd, 1'b1);

        // Tests 2 and 6: 17-byte burst fills the FIFO.
        busy_cycles = 0;
        started.delete();
        for (int i = 0; i < 17; i++) store(DEV, 32'h30 + i);
        addr   = DEV;
        wdata  = 32'h5A;
        wvalid = 1'b1;
        #1;
        chk("t2_stall_when_full", stall, 1'b1);
        wdata = FINI;
        #1;
        chk("t2_fini_never_stalls", stall, 1'b0);
        wvalid = 1'b0;
        addr   = '0;
        wdata  = '0;
        load();
        @(negedge clk);
        chk("t6_status_full_busy", rdata, 32'h3);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t2_drained", busy, 1'b0);
        chk("t2_busy_span", busy_cycles, 1 + 17 * FRAME);
        chk("t2_frame_count", started.size(), 17);
        for (int i = 0; i < 17 && i < started.size(); i++)
            chk("t2_order", started[i], 32'h30 + i);
        load();
        @(negedge clk);
        chk("t6_status_idle", rdata, 32'h0);

        // Test 3: finish code.
        do_reset();
        store(DEV, FINI);
        @(negedge clk);
        chk("t3_fini", fini, 1'b1);
        chk("t3_no_enqueue", busy, 1'b0);
        highs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd === 1'b1) highs++;
        end
        chk("t3_line_idle", highs, 50);
        load();
        @(negedge clk);
        chk("t3_status", rdata, 32'h4);

        // Test 5: reset during DATA with bytes queued.
        do_reset();
        store(DEV, 32'h11);
        store(DEV, 32'h22);
        store(DEV, 32'h33);
        store(DEV, 32'h44);
        tick(8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_txd", txd, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_fini_cleared", fini, 1'b0);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("t5_quiet_after_reset", lows, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_console.md
# mmio_console

Synthesizable MMIO console device on the CPU data bus, decoded by `addr[31]`. Implements the write protocol the simulation top decodes: each store is either a console character or the finish code `32'h00020000`. Characters are queued in a FIFO and serialized as 8N1 UART on `txd_o`; the finish code sets a sticky `fini_o` flag. It sits beside the data memory in `main`, so a board build produces the same console output the simulation prints.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit; must be ≥2.
- `FIFO_DEPTH`, default 16: character FIFO entries; must be a power of two, ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `dbus_addr_i`  in  32  data bus address; the device is selected when `[31]` is 1.
- `dbus_wvalid_i`  in  1  store request.
- `dbus_wdata_i`  in  32  store data.
- `dbus_rvalid_i`  in  1  load request.
- `dbus_stall_o`  out  1  combinational; selected store is refused this cycle.
- `dbus_rdata_o`  out  32  registered status: `{29'b0, fini, busy, full}`.
- `txd_o`  out  1  UART line; idles high.
- `busy_o`  out  1  FIFO non-empty or frame in flight.
- `fini_o`  out  1  sticky finish flag.

## Operation
- `sel = dbus_addr_i[31]`. Bits `[30:0]` are ignored.
- **Store.**
  - A selected store is accepted in any cycle where `dbus_wvalid_i & sel & !dbus_stall_o`.
  - If the store data equals `FINI_CODE`, `fini` is set and nothing is enqueued. Otherwise `wdata[7:0]` is pushed into the FIFO.
- **Stall.**
  - `dbus_stall_o = sel & dbus_wvalid_i & full & (wdata != FINI_CODE)`.
  - `full` is evaluated on the current count. A push is refused while full even if a pop occurs in the same cycle.
  - The CPU holds the request while stalled.
- **Load.** `dbus_rvalid_i & sel` latches the status word into `dbus_rdata_o` on the next edge. Otherwise `dbus_rdata_o` holds its value.
- Unselected requests have no effect.
- **`fini`.** Sticky until reset. Character stores accepted after `fini` is set are still transmitted.
- **TX state machine (`uart_tx`)**, states IDLE, START, DATA, STOP:
  - IDLE→START when the FIFO is non-empty. The byte is popped into the shift register on the same edge.
  - START lasts `CLKS_PER_BIT` cycles with `txd=0`.
  - DATA sends 8 bits, LSB first, each lasting `CLKS_PER_BIT` cycles. A 3-bit index counts the bits.
  - STOP lasts `CLKS_PER_BIT` cycles with `txd=1`.
  - At the end of STOP: if the FIFO is non-empty, pop and go to START (no idle gap); else go to IDLE.
- **`busy`** = FIFO count ≠ 0 or state ≠ IDLE.
- **FIFO.**
  - Read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - The count is `$clog2(FIFO_DEPTH)+1` bits.
  - A simultaneous push and pop keeps the count unchanged.
  - A pop from empty never happens; the state machine checks first.

## Timing
- Reset values: `txd_o=1`, `fini_o=0`, `busy_o=0`, `dbus_rdata_o=0`, FIFO empty, state IDLE, baud counter 0.
- Reset mid-frame: `txd_o` is 1 on the first edge with `rst_i` high. The FIFO contents and `fini` are discarded.
- Store at edge N:
  - FIFO count increments at N+1.
  - If idle, pop at N+1; `txd_o` falls at N+2.
  - Frame length is `10*CLKS_PER_BIT` cycles.
- Back-to-back frames: the stop bit is followed directly by the next start bit.
- Finish store at edge N: `fini_o=1` from N+1.
- Load at edge N: `dbus_rdata_o` is valid from N+1 and reflects state before edge N.
- `dbus_stall_o` has no registered path; the CPU samples it in the same cycle.

## Structure
- Package `mmio_console_pkg`:
  - `FINI_CODE = 32'h00020000`.
  - Status bit indices `ST_FULL=0`, `ST_BUSY=1`, `ST_FINI=2`.
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`.
- Sub-module `uart_tx` (state machine, baud counter, shift register):
  - Ports: `clk_i`, `rst_i`, `valid_i`, `data_i[7:0]`, `ready_o`, `txd_o`.
  - `ready_o` is high in IDLE and in the last STOP cycle.
- The FIFO is inline in `mmio_console`.

## Test plan
1. `CLKS_PER_BIT=4`; store `0x41` to `0x80000000` → after the pop, `txd_o` shows 4×0, bits 1,0,0,0,0,0,1,0 (4 cycles each), then 4×1; `busy_o` drops on the cycle after the stop bit.
2. 17 consecutive stores of `0x30..0x40`, `FIFO_DEPTH=16`:
   - stall is asserted on exactly the cycle the FIFO is full;
   - all 17 bytes appear on `txd_o` in order with no idle gaps between frames.
3. Store `0x00020000` → `fini_o=1` next cycle; FIFO count unchanged; no frame starts; a subsequent load returns `0x4`.
4. Store `0x55` to `0x00001000` → no FIFO change, `txd_o` stays 1, no stall.
5. `rst_i` pulsed during DATA of a frame with 3 bytes queued → `txd_o=1`, `busy_o=0` the next cycle, no further frames.
6. Load during a frame with a full FIFO → `dbus_rdata_o=0x3`; after draining → `0x0`.
